// File: rtl/i2c_cfg_seq_if.sv
// Bus bundle between the config sequencer, the I2C master, the register table and the runtime-update requester.
interface i2c_cfg_seq_if;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 6;

  logic              i2c_exec;
  logic [WORD_W-1:0] i2c_data;
  logic              i2c_done;
  logic              i2c_nack;
  logic [IDX_W-1:0]  tbl_idx;
  logic [WORD_W-1:0] tbl_data;
  logic              upd_req;
  logic [WORD_W-1:0] upd_data;
  logic              upd_ack;

  modport master (
    output i2c_exec, i2c_data, tbl_idx, upd_ack,
    input  i2c_done, i2c_nack, tbl_data, upd_req, upd_data
  );

  modport slave (
    input  i2c_exec, i2c_data, tbl_idx, upd_ack,
    output i2c_done, i2c_nack, tbl_data, upd_req, upd_data
  );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Boot-time codec register sequencer: walks a register table over I2C with retries, then serves runtime writes.
module i2c_cfg_seq #(
  parameter int unsigned REG_NUM   = 23,
  parameter int unsigned INIT_DLY  = 252,
  parameter int unsigned SRST_DLY  = 252,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_DLY = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  i2c_cfg_seq_if.master       bus,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [5:0]          err_idx
);
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned RTY_W   = 3;
  localparam int unsigned MAX_DLY = (INIT_DLY > SRST_DLY)
                                    ? ((INIT_DLY > RETRY_DLY) ? INIT_DLY : RETRY_DLY)
                                    : ((SRST_DLY > RETRY_DLY) ? SRST_DLY : RETRY_DLY);
  localparam int unsigned CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY + 1) : 1;
  // WAIT->ISSUE->exec adds two edges, so the counter is preloaded two short of the delay.
  localparam int unsigned INIT_LD = (INIT_DLY  > 2) ? INIT_DLY  - 2 : 0;
  localparam int unsigned SRST_LD = (SRST_DLY  > 2) ? SRST_DLY  - 2 : 0;
  localparam int unsigned RTRY_LD = (RETRY_DLY > 2) ? RETRY_DLY - 2 : 0;

  typedef enum logic [2:0] {S_WAIT, S_ISSUE, S_XFER, S_DONE, S_ERR, S_UPD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d, err_idx_q, err_idx_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               exec_q, exec_d, ack_q, ack_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               last_idx, rty_max, upd_ok;

  assign last_idx = (idx_q == IDX_W'(REG_NUM - 1));
  assign rty_max  = (rty_q == RTY_W'(MAX_RETRY));
  // No new update is taken in the cycle that acknowledges the previous one.
  assign upd_ok   = bus.upd_req && !ack_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      cnt_q     <= CNT_W'(INIT_LD);
      idx_q     <= '0;
      rty_q     <= '0;
      data_q    <= '0;
      err_idx_q <= '0;
      exec_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rty_q     <= rty_d;
      data_q    <= data_d;
      err_idx_q <= err_idx_d;
      exec_q    <= exec_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (cnt_q == '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_XFER;
      S_XFER: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
            if (last_idx)           state_d = S_DONE;
            else if (idx_q == '0)   state_d = S_WAIT;
            else                    state_d = S_ISSUE;
          end else begin
            state_d = rty_max ? S_ERR : S_WAIT;
          end
        end
      end
      S_DONE: begin
        if (start)       state_d = S_WAIT;
        else if (upd_ok) state_d = S_UPD;
      end
      S_ERR:   if (start) state_d = S_WAIT;
      S_UPD:   if (bus.i2c_done) state_d = S_DONE;
      default: state_d = S_WAIT;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rty_d     = rty_q;
    data_d    = data_q;
    err_idx_d = err_idx_q;
    exec_d    = 1'b0;
    ack_d     = 1'b0;
    case (state_q)
      S_WAIT: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      S_ISSUE: begin
        data_d = bus.tbl_data;
        exec_d = 1'b1;
      end
      S_XFER: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
            rty_d = '0;
            if (!last_idx) begin
              idx_d = idx_q + IDX_W'(1);
              if (idx_q == '0) cnt_d = CNT_W'(SRST_LD);
            end
          end else if (rty_max) begin
            err_idx_d = idx_q;
          end else begin
            rty_d = rty_q + RTY_W'(1);
            cnt_d = CNT_W'(RTRY_LD);
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          idx_d = '0;
          rty_d = '0;
          cnt_d = CNT_W'(INIT_LD);
        end else if (state_q == S_DONE && upd_ok) begin
          data_d = bus.upd_data;
          exec_d = 1'b1;
        end
      end
      S_UPD: ack_d = bus.i2c_done;
      default: ;
    endcase
    busy_d = !(state_d inside {S_DONE, S_ERR});
    done_d = (state_d inside {S_DONE, S_UPD});
    err_d  = (state_d == S_ERR);
  end

  assign bus.i2c_exec = exec_q;
  assign bus.i2c_data = data_q;
  assign bus.tbl_idx  = idx_q;
  assign bus.upd_ack  = ack_q;
  assign busy         = busy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign err_idx      = err_idx_q;
endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Randomized bench for i2c_cfg_seq: a transaction-level model predicts every exec (cycle and word) into a scoreboard.
module tb_i2c_cfg_seq;
  localparam int REG_NUM   = 4;
  localparam int INIT_DLY  = 8;
  localparam int SRST_DLY  = 4;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_DLY = 16;
  localparam int BUDGET    = 200;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, cfg_done, cfg_err;
  logic [5:0] err_idx;

  i2c_cfg_seq_if bus();

  i2c_cfg_seq #(
    .REG_NUM(REG_NUM), .INIT_DLY(INIT_DLY), .SRST_DLY(SRST_DLY),
    .MAX_RETRY(MAX_RETRY), .RETRY_DLY(RETRY_DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [64];
  assign bus.tbl_data = tbl[bus.tbl_idx];

  // Edges counted since the last reset release.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  exp_t exp_q[$];
  int   nack_plan [REG_NUM];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(input int c, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.i2c_exec) begin
        if (exp_q.size() == 0) begin
          check("unexpected_exec", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("exec_cycle", cyc, e.cyc);
          check("exec_data", int'(bus.i2c_data), int'(e.data));
        end
      end
    end
  endtask

  task automatic wait_exec(output int ec, output bit ok);
    ok = 1'b0;
    ec = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (bus.i2c_exec) begin
        ec = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("exec_timeout", 0, 1);
  endtask

  // Called right after the exec negedge; the done pulse is sampled by edge ec+d.
  task automatic respond(input int d, input bit nack);
    repeat (d - 1) @(negedge clk);
    bus.i2c_done = 1'b1;
    bus.i2c_nack = nack;
    @(negedge clk);
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    s = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference walk of the table: base is the edge that (re)started the sequence.
  task automatic run_cfg(input int base, input int dly, output bit err_seen,
                         output int err_i, output int last_dc);
    int idx, nk, ec, d, dc;
    bit ok, nack;
    idx = 0; nk = 0; err_seen = 1'b0; err_i = 0; last_dc = 0;
    push(base + INIT_DLY, tbl[0]);
    forever begin
      wait_exec(ec, ok);
      if (!ok) return;
      d    = (dly > 0) ? dly : int'($urandom_range(1, 6));
      nack = (nk < nack_plan[idx]);
      respond(d, nack);
      dc = ec + d;
      last_dc = dc;
      if (nack) begin
        nk++;
        if (nk > MAX_RETRY) begin
          err_seen = 1'b1;
          err_i    = idx;
          return;
        end
        push(dc + RETRY_DLY, tbl[idx]);
      end else begin
        nk = 0;
        if (idx == REG_NUM - 1) return;
        push(dc + ((idx == 0) ? SRST_DLY : 1), tbl[idx + 1]);
        idx++;
      end
    end
  endtask

  // Serves an update whose exec is already in the scoreboard; req is held one cycle past the ack.
  task automatic finish_upd();
    int ec, d;
    bit ok;
    wait_exec(ec, ok);
    if (!ok) return;
    check("upd_busy", int'(busy), 1);
    check("upd_cfg_done_hold", int'(cfg_done), 1);
    d = int'($urandom_range(1, 5));
    respond(d, 1'($urandom_range(0, 1)));
    check("upd_ack_pulse", int'(bus.upd_ack), 1);
    check("upd_cfg_done_after", int'(cfg_done), 1);
    @(negedge clk);
    check("upd_ack_single", int'(bus.upd_ack), 0);
    bus.upd_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_exec", int'(bus.i2c_exec), 0);
    check("rst_data", int'(bus.i2c_data), 0);
    check("rst_idx", int'(bus.tbl_idx), 0);
    check("rst_cfg_done", int'(cfg_done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_err_idx", int'(err_idx), 0);
    check("rst_upd_ack", int'(bus.upd_ack), 0);
    check("rst_busy", int'(busy), 1);
  endtask

  task automatic set_plan(input bool_rand);
  endtask

  task automatic random_plan(input bit allow_err);
    for (int i = 0; i < REG_NUM; i++) begin
      if (allow_err && $urandom_range(0, 7) == 0) nack_plan[i] = MAX_RETRY + 1;
      else nack_plan[i] = int'($urandom_range(0, MAX_RETRY));
    end
  endtask

  task automatic check_outcome(input bit err_seen, input int err_i);
    check("out_cfg_err", int'(cfg_err), int'(err_seen));
    check("out_cfg_done", int'(cfg_done), int'(!err_seen));
    check("out_busy", int'(busy), 0);
    if (err_seen) check("out_err_idx", int'(err_idx), err_i);
  endtask

  initial begin
    bit err_seen;
    int err_i, last_dc, s, ec;
    bit ok;
    logic [15:0] ud;

    for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
    start = 1'b0;
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    bus.upd_req  = 1'b0;
    bus.upd_data = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_reset_vals();
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean pass, done returned 3 cycles after each exec
    for (int i = 0; i < REG_NUM; i++) nack_plan[i] = 0;
    run_cfg(0, 3, err_seen, err_i, last_dc);
    check_outcome(1'b0, 0);

    // Two NACKs on entry 2 are absorbed by retries
    pulse_start(s);
    nack_plan[2] = 2;
    run_cfg(s, 0, err_seen, err_i, last_dc);
    check_outcome(1'b0, 0);

    // Four NACKs on entry 3 exhaust the retries
    pulse_start(s);
    nack_plan[2] = 0;
    nack_plan[3] = MAX_RETRY + 1;
    run_cfg(s, 0, err_seen, err_i, last_dc);
    check_outcome(1'b1, 3);
    bus.upd_req  = 1'b1;
    bus.upd_data = 16'h1234;
    repeat (40) @(negedge clk);
    bus.upd_req = 1'b0;
    check("err_hold", int'(cfg_err), 1);
    check("err_not_busy", int'(busy), 0);
    pulse_start(s);
    random_plan(1'b0);
    run_cfg(s, 0, err_seen, err_i, last_dc);
    check_outcome(1'b0, 0);

    // Random reruns, some ending in ERR
    for (int r = 0; r < 4; r++) begin
      pulse_start(s);
      random_plan(1'b1);
      run_cfg(s, 0, err_seen, err_i, last_dc);
      check_outcome(err_seen, err_i);
    end
    if (cfg_err) begin
      pulse_start(s);
      random_plan(1'b0);
      run_cfg(s, 0, err_seen, err_i, last_dc);
      check_outcome(1'b0, 0);
    end

    // Runtime update from DONE
    bus.upd_data = 16'h6C3C;
    bus.upd_req  = 1'b1;
    push(cyc + 1, 16'h6C3C);
    finish_upd();

    // start and upd_req together: rerun first, update afterwards
    ud = 16'($urandom);
    bus.upd_data = ud;
    bus.upd_req  = 1'b1;
    pulse_start(s);
    random_plan(1'b0);
    run_cfg(s, 0, err_seen, err_i, last_dc);
    check_outcome(1'b0, 0);
    push(last_dc + 1, ud);
    finish_upd();

    // Reset during the entry 1 transfer, spurious done after release
    pulse_start(s);
    push(s + INIT_DLY, tbl[0]);
    wait_exec(ec, ok);
    respond(2, 1'b0);
    push(ec + 2 + SRST_DLY, tbl[1]);
    wait_exec(ec, ok);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i2c_done = 1'b1;
    @(negedge clk);
    bus.i2c_done = 1'b0;
    check("spurious_idx", int'(bus.tbl_idx), 0);
    check("spurious_busy", int'(busy), 1);
    random_plan(1'b0);
    run_cfg(0, 0, err_seen, err_i, last_dc);
    check_outcome(1'b0, 0);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 Parameter REG_NUM, default 23: number of table entries to write (1..63).
REQ-002 Parameter INIT_DLY, default 252: clk cycles from reset release to the first i2c_exec.
REQ-003 Parameter SRST_DLY, default 252: clk cycles after entry 0 completes before entry 1 is issued (codec soft-reset settle).
REQ-004 Parameter MAX_RETRY, default 3: re-attempts per entry after a NACK (0..7).
REQ-005 Parameter RETRY_DLY, default 16: clk cycles between a NACK and its retry.
REQ-006 clk  in  1  sequencer clock, typically 1 MHz.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  single-cycle pulse that restarts the full sequence; honoured only in DONE or ERR.
REQ-009 i2c_done  in  1  single-cycle pulse: the I2C master finished a transfer.
REQ-010 i2c_nack  in  1  valid with i2c_done; 1 means the slave did not acknowledge.
REQ-011 tbl_idx  out  6  index of the current table entry; drives an external combinational table.
REQ-012 tbl_data  in  16  table word for tbl_idx: {7-bit reg addr, 9-bit data}.
REQ-013 upd_req  in  1  level runtime-write request; held high until upd_ack.
REQ-014 upd_data  in  16  runtime word; sampled when upd_req is accepted.
REQ-015 upd_ack  out  1  single-cycle pulse: the runtime write completed (ACK or final NACK).
REQ-016 i2c_exec  out  1  single-cycle pulse that triggers one I2C write.
REQ-017 i2c_data  out  16  word to be written.
REQ-018 busy  out  1  high in every state except DONE and ERR.
REQ-019 cfg_done  out  1  level: the full table was written successfully.
REQ-020 cfg_err  out  1  level: an entry failed after MAX_RETRY retries.
REQ-021 err_idx  out  6  index of the failing entry; valid while cfg_err is high.

Function
REQ-022 State set: WAIT, ISSUE, XFER, DONE, ERR, UPD. The WAIT state is a countdown on a delay counter sized for the largest delay parameter.
REQ-023 Reset release -> WAIT, loaded with INIT_DLY, tbl_idx=0, retry count=0.
REQ-024 WAIT counter reaches 0 -> ISSUE.
REQ-025 In ISSUE: i2c_data<=tbl_data, i2c_exec=1 for exactly 1 cycle, then -> XFER.
REQ-026 i2c_data stays stable from the i2c_exec cycle until the next ISSUE or UPD load.
REQ-027 XFER, i2c_done with i2c_nack=0, tbl_idx==REG_NUM-1 -> DONE; cfg_done=1 in the following cycle.
REQ-028 XFER, i2c_done with i2c_nack=0, tbl_idx==0 -> tbl_idx=1, WAIT loaded with SRST_DLY.
REQ-029 XFER, i2c_done with i2c_nack=0, any other index -> tbl_idx+1, retry count=0, ISSUE on the next cycle (no gap).
REQ-030 XFER, i2c_done with i2c_nack=1 and retry count<MAX_RETRY -> retry count+1, WAIT loaded with RETRY_DLY, then the same index is reissued.
REQ-031 XFER, i2c_done with i2c_nack=1 and retry count==MAX_RETRY -> ERR: cfg_err=1, err_idx=tbl_idx, cfg_done=0.
REQ-032 i2c_done is ignored in every state other than XFER and UPD.
REQ-033 DONE with start=1 -> clear cfg_done, tbl_idx=0, WAIT loaded with INIT_DLY.
REQ-034 ERR with start=1 -> clear cfg_err, tbl_idx=0, WAIT loaded with INIT_DLY.
REQ-035 DONE with upd_req=1 and start=0 -> latch upd_data into i2c_data, pulse i2c_exec, -> UPD; cfg_done stays 1.
REQ-036 DONE with start and upd_req both high -> start wins; upd_req stays pending.
REQ-037 UPD, i2c_done (any nack) -> upd_ack pulses 1 cycle, -> DONE; a new request is not accepted in the upd_ack cycle.
REQ-038 upd_req is ignored while busy or in ERR; start is ignored while busy.
REQ-039 i2c_exec never asserts in two consecutive cycles and never while a transfer is outstanding.

Reset
REQ-040 Asynchronous assertion; all outputs and state cleared within the same cycle.
REQ-041 Reset values: i2c_exec=0, i2c_data=0, tbl_idx=0, cfg_done=0, cfg_err=0, err_idx=0, upd_ack=0, busy=1.
REQ-042 Reset mid-transfer abandons the transfer; after release the sequence restarts from INIT_DLY and entry 0.

Verification
REQ-043 REG_NUM=4, INIT_DLY=8, SRST_DLY=4, done returned 3 cycles after each exec -> first exec at cycle 8; entry 1 exec 4 cycles after done 0; cfg_done=1 after the 4th done.
REQ-044 NACK twice on entry 2, MAX_RETRY=3 -> entry 2 issued 3 times with RETRY_DLY gaps; sequence then completes with cfg_done=1.
REQ-045 NACK 4 times on entry 3 -> cfg_err=1, err_idx=3, busy=0, no further exec; start -> full rerun and cfg_done=1.
REQ-046 After DONE, upd_req with upd_data=0x6C3C -> one exec with i2c_data=0x6C3C, upd_ack pulse, cfg_done stays 1.
REQ-047 start and upd_req in the same DONE cycle -> rerun first; update served after the new cfg_done.
REQ-048 rst_n low during entry 1 transfer, spurious i2c_done afterwards -> outputs at reset values, spurious done ignored, restart at entry 0.
